// File: rtl/mio_pkg.sv
// Shared defaults for the mio_modulo_or block and its counter.
//   MIO_WIDTH : default operand/result width
//   MIO_CNT_W : default width of the "z high" cycle counter
package mio_pkg;
  localparam int MIO_WIDTH = 1;
  localparam int MIO_CNT_W = 16;
endpackage : mio_pkg

// File: rtl/mio_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears count
//   clr   : synchronous clear, wins over inc
//   inc   : advance count by one, sticking at all-ones
//   count : current count value
module mio_sat_counter
  import mio_pkg::*;
#(
  parameter int CNT_W = MIO_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Once all ones the counter sticks there instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) r = v;
    else    r = v + 1'b1;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule : mio_sat_counter

// File: rtl/mio_modulo_or.sv
// Bitwise two-input OR with a clocked observation path.
// Ports:
//   clk      : rising-edge clock (clocked path only)
//   rst_n    : asynchronous active-low reset (clocked path only)
//   x, y     : operands
//   en       : enable for the clocked path; registers hold when low
//   clr      : synchronous clear of hi_count
//   z        : combinational x | y, independent of clock and reset
//   z_q      : z registered on enabled edges
//   z_rise   : one-cycle per-bit pulse when z_q goes 0 -> 1
//   hi_count : saturating count of enabled cycles where any bit of z is 1
module mio_modulo_or
  import mio_pkg::*;
#(
  parameter int WIDTH = MIO_WIDTH,
  parameter int CNT_W = MIO_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_q,
  output logic [WIDTH-1:0] z_rise,
  output logic [CNT_W-1:0] hi_count
);

  logic hi_inc_p0;

  // Stage p0: combinational result, the primary function of the block.
  assign z         = x | y;
  assign hi_inc_p0 = en & (|z);

  // Stage p1: registered observation of z. z_rise compares the new z
  // against the previous z_q, so after reset a high z always pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q    <= '0;
      z_rise <= '0;
    end else if (en) begin
      z_q    <= z;
      z_rise <= z & ~z_q;
    end else begin
      z_rise <= '0;
    end
  end

  mio_sat_counter #(
    .CNT_W(CNT_W)
  ) u_hi_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (hi_inc_p0),
    .count(hi_count)
  );

endmodule : mio_modulo_or

// File: tb/tb_mio_modulo_or.sv
module tb_mio_modulo_or;

  logic clk;
  logic rst_n;

  // dut_a: WIDTH=4, CNT_W=16
  logic [3:0]  xa, ya, za, zqa, risea;
  logic        ena, clra;
  logic [15:0] cnta;
  // dut_b: WIDTH=1, CNT_W=3
  logic        xb, yb, zb, zqb, riseb, enb, clrb;
  logic [2:0]  cntb;
  // dut_c: WIDTH=1, clock idle, reset held asserted
  logic        clk_c, rst_c, xc, yc, zc, zqc, risec;
  logic [15:0] cntc;

  int checks = 0;
  int errors = 0;

  mio_modulo_or #(.WIDTH(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .x(xa), .y(ya), .en(ena), .clr(clra),
    .z(za), .z_q(zqa), .z_rise(risea), .hi_count(cnta)
  );

  mio_modulo_or #(.WIDTH(1), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .x(xb), .y(yb), .en(enb), .clr(clrb),
    .z(zb), .z_q(zqb), .z_rise(riseb), .hi_count(cntb)
  );

  mio_modulo_or #(.WIDTH(1), .CNT_W(16)) dut_c (
    .clk(clk_c), .rst_n(rst_c), .x(xc), .y(yc), .en(1'b1), .clr(1'b0),
    .z(zc), .z_q(zqc), .z_rise(risec), .hi_count(cntc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  x, y;
    logic        en, clr;
    logic [3:0]  ez, ezq, erise;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic        ezc[4];
    logic [3:0]  mzq, mz, mrise;
    int          mcnt;
    int          bcnt;

    clk_c = 1'b0; rst_c = 1'b0; xc = 1'b0; yc = 1'b0;
    rst_n = 1'b0;
    xa = '0; ya = '0; ena = 1'b0; clra = 1'b0;
    xb = 1'b0; yb = 1'b0; enb = 1'b0; clrb = 1'b0;

    tbl[0] = '{4'b1010, 4'b0110, 1'b1, 1'b0, 4'b1110, 4'b1110, 4'b1110, 16'd1};
    tbl[1] = '{4'b1010, 4'b0110, 1'b1, 1'b0, 4'b1110, 4'b1110, 4'b0000, 16'd2};
    tbl[2] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 16'd2};
    tbl[3] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 16'd2};
    tbl[4] = '{4'b0001, 4'b1000, 1'b1, 1'b0, 4'b1001, 4'b1001, 4'b1001, 16'd3};
    tbl[5] = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0110, 16'd0};
    tbl[6] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0000, 16'd0};
    tbl[7] = '{4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0100, 4'b0100, 4'b0000, 16'd1};

    // OR truth table on the unclocked instance
    ezc = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      logic [1:0] p;
      p = 2'(i);
      xc = p[1]; yc = p[0];
      #10;
      chk($sformatf("truth_%0d%0d", p[1], p[0]), 32'(zc), 32'(ezc[i]));
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_zq_a", 32'(zqa), 32'd0);
    chk("rst_rise_a", 32'(risea), 32'd0);
    chk("rst_cnt_a", 32'(cnta), 32'd0);
    chk("rst_zq_b", 32'(zqb), 32'd0);
    chk("rst_cnt_b", 32'(cntb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed vector table on dut_a
    for (int i = 0; i < 8; i++) begin
      xa = tbl[i].x; ya = tbl[i].y; ena = tbl[i].en; clra = tbl[i].clr;
      #1;
      chk($sformatf("tbl%0d_z", i), 32'(za), 32'(tbl[i].ez));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_zq", i), 32'(zqa), 32'(tbl[i].ezq));
      chk($sformatf("tbl%0d_rise", i), 32'(risea), 32'(tbl[i].erise));
      chk($sformatf("tbl%0d_cnt", i), 32'(cnta), 32'(tbl[i].ecnt));
    end

    // randomized run on dut_a against a reference model
    mzq  = tbl[7].ezq;
    mcnt = int'(tbl[7].ecnt);
    for (int i = 0; i < 300; i++) begin
      xa   = 4'($urandom);
      ya   = 4'($urandom);
      ena  = ($urandom_range(0, 3) != 0);
      clra = ($urandom_range(0, 19) == 0);
      mz   = xa | ya;
      if (ena) begin
        mrise = mz & ~mzq;
        mzq   = mz;
      end else begin
        mrise = 4'b0000;
      end
      if (clra)                    mcnt = 0;
      else if (ena && mz != 4'b0)  mcnt = (mcnt + 1 > 65535) ? 65535 : mcnt + 1;
      #1;
      chk("rnd_z", 32'(za), 32'(mz));
      @(posedge clk); #1;
      chk("rnd_zq", 32'(zqa), 32'(mzq));
      chk("rnd_rise", 32'(risea), 32'(mrise));
      chk("rnd_cnt", 32'(cnta), 32'(mcnt));
    end

    // dut_b: enable hold, then saturation at 7, then clear
    xb = 1'b1; yb = 1'b0; enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_z", 32'(zb), 32'd1);
      chk("hold_zq", 32'(zqb), 32'd0);
      chk("hold_cnt", 32'(cntb), 32'd0);
    end
    enb = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bcnt = (bcnt + 1 > 7) ? 7 : bcnt + 1;
      chk($sformatf("sat_cnt_%0d", i + 1), 32'(cntb), 32'(bcnt));
      if (i == 4) chk("en5_zq", 32'(zqb), 32'd1);
    end
    clrb = 1'b1;
    @(posedge clk); #1;
    chk("clr_cnt", 32'(cntb), 32'd0);
    clrb = 1'b0;

    // asynchronous reset mid-run
    xa = 4'b0101; ya = 4'b0010; ena = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("arst_zq_a", 32'(zqa), 32'd0);
    chk("arst_rise_a", 32'(risea), 32'd0);
    chk("arst_cnt_a", 32'(cnta), 32'd0);
    chk("arst_z_a", 32'(za), 32'b0111);
    chk("arst_zq_b", 32'(zqb), 32'd0);
    chk("arst_cnt_b", 32'(cntb), 32'd0);
    xa = 4'b0001; ya = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rise", 32'(risea), 32'b0001);
    chk("post_rst_zq", 32'(zqa), 32'b0001);
    chk("post_rst_cnt", 32'(cnta), 32'd1);
    chk("post_rst_rise_b", 32'(riseb), 32'd1);
    chk("post_rst_cnt_b", 32'(cntb), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mio_modulo_or
